// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/busy/done handshake, operands and Hi/Lo results of muldiv_seq
// Is_Unsigned exists only when MULDIV_UNSIGNED_EN is defined.
interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic Start, Mode;
  logic [WIDTH-1:0] Op_A, Op_B;
`ifdef MULDIV_UNSIGNED_EN
  logic Is_Unsigned;
`endif
  logic Busy, Done, Zero_Div;
  logic [WIDTH-1:0] Hi, Lo;
  modport master(
`ifdef MULDIV_UNSIGNED_EN
    output Is_Unsigned,
`endif
    output Start, Mode, Op_A, Op_B,
    input Busy, Done, Zero_Div, Hi, Lo
  );
  modport slave(
`ifdef MULDIV_UNSIGNED_EN
    input Is_Unsigned,
`endif
    input Start, Mode, Op_A, Op_B,
    output Busy, Done, Zero_Div, Hi, Lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed shift-add multiply / restoring divide with Hi/Lo results
// Define MULDIV_UNSIGNED_EN to add the Is_Unsigned (multu/divu) option.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic Reset_In,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic mode_r, neg_p, neg_r, uns_in, sa, sb, zdiv, launch;
  logic [WIDTH:0] a_r, sum, shf, dif;
  logic [WIDTH-1:0] q_r, b_r, mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_f;
`ifdef MULDIV_UNSIGNED_EN
  assign uns_in = bus.Is_Unsigned;
`else
  assign uns_in = 1'b0;
`endif
  assign sa = bus.Op_A[WIDTH-1] & ~uns_in;
  assign sb = bus.Op_B[WIDTH-1] & ~uns_in;
  always_comb begin
    zdiv = state == IDLE && bus.Start && bus.Mode && bus.Op_B == '0;
    launch = state == IDLE && bus.Start && !zdiv;
    state_d = launch ? CALC : state == CALC ? (cnt == CW'(WIDTH - 1) ? FIX : CALC) : IDLE;
    mag_a = sa ? -bus.Op_A : bus.Op_A;
    mag_b = sb ? -bus.Op_B : bus.Op_B;
    sum = a_r + {1'b0, b_r & {WIDTH{q_r[0]}}};
    shf = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
    dif = shf - {1'b0, b_r};
    prod = {a_r[WIDTH-1:0], q_r};
    prod_f = neg_p ? -prod : prod;
  end
  // a_r:q_r is the multiply accumulator {high, multiplier} or the divide {remainder, dividend/quotient}
  always_ff @(posedge clk or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
      cnt <= '0;
      mode_r <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      a_r <= '0;
      q_r <= '0;
      b_r <= '0;
      bus.Busy <= 1'b0;
      bus.Done <= 1'b0;
      bus.Zero_Div <= 1'b0;
      bus.Hi <= '0;
      bus.Lo <= '0;
    end else begin
      state <= state_d;
      bus.Busy <= state_d != IDLE;
      bus.Done <= zdiv || state == FIX;
      bus.Zero_Div <= zdiv;
      if (launch) begin
        cnt <= '0;
        mode_r <= bus.Mode;
        neg_p <= sa ^ sb;
        neg_r <= sa;
        a_r <= '0;
        q_r <= bus.Mode ? mag_a : mag_b;
        b_r <= bus.Mode ? mag_b : mag_a;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        // a negative trial difference means the divisor did not fit: restore
        a_r <= mode_r ? (dif[WIDTH] ? shf : dif) : {1'b0, sum[WIDTH:1]};
        q_r <= mode_r ? {q_r[WIDTH-2:0], ~dif[WIDTH]} : {sum[0], q_r[WIDTH-1:1]};
      end else if (state == FIX) begin
        bus.Hi <= mode_r ? (neg_r ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0]) : prod_f[2*WIDTH-1:WIDTH];
        bus.Lo <= mode_r ? (neg_p ? -q_r : q_r) : prod_f[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus handshake corner sequences for muldiv_seq
module tb_muldiv_seq;
  localparam int W = 32;
  logic clk = 1'b0;
  logic Reset_In = 1'b1;
  muldiv_seq_if #(.WIDTH(W)) bus();
  muldiv_seq #(.WIDTH(W)) dut(.clk(clk), .Reset_In(Reset_In), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic mode;
    logic [W-1:0] a, b, hi, lo;
    logic zd;
    int lat, busy;
  } vec_t;
  vec_t v[12];
  int tests = 0, fails = 0;
  logic [W-1:0] r_hi, r_lo;
  logic r_zd;
  int r_lat, r_busy, n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // r_lat counts from the Start edge to the edge that first samples Done high
  task automatic do_op(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b, input logic now);
    if (!now) @(negedge clk);
    bus.Start = 1'b1;
    bus.Mode = mode;
    bus.Op_A = a;
    bus.Op_B = b;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    r_lat = 0;
    r_busy = 0;
    while (!bus.Done && r_lat < 60) begin
      r_busy += int'(bus.Busy);
      @(posedge clk);
      #1 r_lat++;
    end
    r_lat++;
    r_hi = bus.Hi;
    r_lo = bus.Lo;
    r_zd = bus.Zero_Div;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 1'b0;
    bus.Mode = 1'b0;
    bus.Op_A = '0;
    bus.Op_B = '0;
`ifdef MULDIV_UNSIGNED_EN
    bus.Is_Unsigned = 1'b0;
`endif
    v[0]  = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33};
    v[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33};
    v[2]  = '{1'b1, 32'h56781234, 32'h00010000, 32'h00001234, 32'h00005678, 1'b0, 34, 33};
    v[3]  = '{1'b1, 32'd5, 32'd0, 32'h00001234, 32'h00005678, 1'b1, 1, 0};
    v[4]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34, 33};
    v[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33};
    v[6]  = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 33};
    v[7]  = '{1'b0, 32'd6, 32'd9, 32'd0, 32'd54, 1'b0, 34, 33};
    v[8]  = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 33};
    v[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 34, 33};
    v[10] = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2, 1'b0, 34, 33};
    v[11] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34, 33};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(bus.Busy), 64'd0);
    chk("reset done", 64'(bus.Done), 64'd0);
    chk("reset zero_div", 64'(bus.Zero_Div), 64'd0);
    chk("reset hi", 64'(bus.Hi), 64'd0);
    chk("reset lo", 64'(bus.Lo), 64'd0);
    @(negedge clk) Reset_In = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(v[i].mode, v[i].a, v[i].b, 1'b0);
      chk($sformatf("v%0d hi", i), 64'(r_hi), 64'(v[i].hi));
      chk($sformatf("v%0d lo", i), 64'(r_lo), 64'(v[i].lo));
      chk($sformatf("v%0d zero_div", i), 64'(r_zd), 64'(v[i].zd));
      chk($sformatf("v%0d latency", i), 64'(r_lat), 64'(v[i].lat));
      chk($sformatf("v%0d busy cycles", i), 64'(r_busy), 64'(v[i].busy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse", i), 64'({bus.Done, bus.Zero_Div, bus.Busy}), 64'd0);
    end

    // second Start mid-CALC must be ignored
    @(negedge clk);
    bus.Start = 1'b1; bus.Mode = 1'b0; bus.Op_A = 32'd6; bus.Op_B = 32'd9;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1 n++;
    end
    bus.Start = 1'b1; bus.Mode = 1'b1; bus.Op_A = 32'd100; bus.Op_B = 32'd7;
    @(posedge clk);
    #1 n++;
    bus.Start = 1'b0;
    while (!bus.Done && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("restart latency", 64'(n + 1), 64'd34);
    chk("restart hi", 64'(bus.Hi), 64'd0);
    chk("restart lo", 64'(bus.Lo), 64'd54);
    @(posedge clk);
    #1 chk("restart no relaunch", 64'(bus.Busy), 64'd0);

    // asynchronous reset at iteration 10
    @(negedge clk);
    bus.Start = 1'b1; bus.Mode = 1'b0; bus.Op_A = 32'd6; bus.Op_B = 32'd9;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (10) @(posedge clk);
    #2 Reset_In = 1'b1;
    #1;
    chk("abort busy", 64'(bus.Busy), 64'd0);
    chk("abort hi", 64'(bus.Hi), 64'd0);
    chk("abort lo", 64'(bus.Lo), 64'd0);
    @(negedge clk) Reset_In = 1'b0;
    do_op(1'b1, 32'd100, 32'd7, 1'b0);
    chk("post-abort hi", 64'(r_hi), 64'd2);
    chk("post-abort lo", 64'(r_lo), 64'd14);
    chk("post-abort latency", 64'(r_lat), 64'd34);

    // Start presented in the Done cycle is accepted
    do_op(1'b0, 32'd3, 32'd5, 1'b1);
    chk("back-to-back lo", 64'(r_lo), 64'd15);
    chk("back-to-back latency", 64'(r_lat), 64'd34);
    chk("back-to-back busy", 64'(r_busy), 64'd33);

`ifdef MULDIV_UNSIGNED_EN
    bus.Is_Unsigned = 1'b1;
    do_op(1'b1, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("divu hi", 64'(r_hi), 64'd1);
    chk("divu lo", 64'(r_lo), 64'h7FFFFFFF);
    chk("divu latency", 64'(r_lat), 64'd34);
    do_op(1'b0, 32'hFFFFFFFF, 32'd2, 1'b0);
    chk("multu hi", 64'(r_hi), 64'd1);
    chk("multu lo", 64'(r_lo), 64'hFFFFFFFE);
    bus.Is_Unsigned = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
